// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin, packet-locking arbiter feeding the source-side push port of a cdc_fifo_2phase.
// A winner keeps the grant until its last beat is accepted; every beat is tagged with its index.
module cdc_fifo_src_arbiter #(
    parameter int unsigned NumReq   = 4,
    parameter type         T        = logic,
    parameter int unsigned MaxBeats = 16,
    localparam int unsigned IdxWidth = $clog2(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   en_i,
    input  logic [NumReq-1:0]   req_valid_i,
    input  T     [NumReq-1:0]   req_data_i,
    input  logic [NumReq-1:0]   req_last_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic                fifo_valid_o,
    output T                    fifo_data_o,
    output logic [IdxWidth-1:0] fifo_idx_o,
    input  logic                fifo_ready_i,
    output logic                overrun_o
);

    localparam int unsigned BeatW = $clog2(MaxBeats + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] gnt_q, gnt_d;
    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [BeatW-1:0]    beats_q, beats_d;
    logic                overrun_q, overrun_d;

    logic [IdxWidth-1:0] sel, g, g_inc, scan_idx;
    logic                sel_vld, grant_act, hs;

    // First enabled, valid requester at or after the round-robin pointer.
    always_comb begin
        sel      = '0;
        sel_vld  = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            scan_idx = IdxWidth'((32'(rr_q) + k) % NumReq);
            if (!sel_vld && req_valid_i[scan_idx] && en_i[scan_idx]) begin
                sel_vld = 1'b1;
                sel     = scan_idx;
            end
        end
    end

    always_comb begin
        g         = (state_q == LOCKED) ? gnt_q : sel;
        grant_act = (state_q == LOCKED) || sel_vld;
        g_inc     = (g == IdxWidth'(NumReq - 1)) ? '0 : g + IdxWidth'(1);

        fifo_valid_o = grant_act & req_valid_i[g];
        fifo_data_o  = req_data_i[g];
        fifo_idx_o   = g;
        req_ready_o  = '0;
        if (grant_act) begin
            req_ready_o[g] = fifo_ready_i;
        end
        hs = fifo_valid_o & fifo_ready_i;

        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        beats_d   = beats_q;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    if (hs && req_last_i[sel]) begin
                        rr_d    = g_inc;
                        beats_d = '0;
                    end else begin
                        // Lock even without a handshake so the offer cannot move.
                        state_d = LOCKED;
                        gnt_d   = sel;
                        if (hs) begin
                            beats_d = BeatW'(1);
                        end
                    end
                end
            end
            LOCKED: begin
                if (hs) begin
                    if (req_last_i[gnt_q]) begin
                        state_d = IDLE;
                        rr_d    = g_inc;
                        beats_d = '0;
                    end else if (beats_q != BeatW'(MaxBeats)) begin
                        beats_d = beats_q + BeatW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (hs && !req_last_i[g] && (beats_q == BeatW'(MaxBeats - 1))) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_q      <= '0;
            beats_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            beats_q   <= beats_d;
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Bench for cdc_fifo_src_arbiter: packet-level requester model, per-cycle reference check,
// and literal grant-order/overrun expectations for the directed scenarios.
module tb_cdc_fifo_src_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      en, vld, last, ready;
    logic [3:0][7:0] data;
    logic            fvld, fready, ovr;
    logic [7:0]      fdata;
    logic [1:0]      fidx;

    cdc_fifo_src_arbiter #(
        .NumReq  (N),
        .T       (logic [7:0]),
        .MaxBeats(MB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .req_valid_i (vld),
        .req_data_i  (data),
        .req_last_i  (last),
        .req_ready_o (ready),
        .fifo_valid_o(fvld),
        .fifo_data_o (fdata),
        .fifo_idx_o  (fidx),
        .fifo_ready_i(fready),
        .overrun_o   (ovr)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int left[4], plen[4], sent[4];
    int hs_log[$];
    bit chk_on = 1'b0;

    // Reference state: who owns the port, where the next scan starts, beats of the open packet.
    bit m_locked = 1'b0;
    int m_gnt = 0, m_rr = 0, m_beats = 0;
    bit m_ovr = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void apply();
        for (int i = 0; i < 4; i++) begin
            vld[i]  = (left[i] > 0);
            last[i] = (left[i] == 1) || ((sent[i] % plen[i]) == plen[i] - 1);
            data[i] = 8'(i * 64 + sent[i] % 64);
        end
    endfunction

    task automatic load(input int i, input int n, input int len);
        left[i] = n;
        plen[i] = len;
        sent[i] = 0;
    endtask

    // One clock: note which requesters were accepted, then advance them after the edge.
    task automatic step();
        logic [3:0] acc;
        @(negedge clk);
        acc = vld & ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                sent[i]++;
                left[i]--;
            end
        end
        apply();
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    function automatic int log_code();
        int c = 0;
        foreach (hs_log[k]) c = c * 16 + hs_log[k];
        return c;
    endfunction

    always @(negedge clk) begin : model
        int  g;
        bit  have;
        bit  ev;
        bit  mhs;
        if (chk_on) begin
            have = 1'b0;
            g    = 0;
            if (m_locked) begin
                have = 1'b1;
                g    = m_gnt;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!have && vld[(m_rr + k) % N] && en[(m_rr + k) % N]) begin
                        have = 1'b1;
                        g    = (m_rr + k) % N;
                    end
                end
            end
            ev  = have && vld[g];
            mhs = ev && fready;
            check("valid", fvld, ev);
            if (have) begin
                check("idx", fidx, g);
                check("data", fdata, data[g]);
                check("ready", ready, fready ? (1 << g) : 0);
            end
            check("overrun", ovr, m_ovr);
            if (rst_n && fvld && fready) hs_log.push_back(int'(fidx));

            if (!rst_n) begin
                m_locked = 1'b0; m_gnt = 0; m_rr = 0; m_beats = 0; m_ovr = 1'b0;
            end else if (have) begin
                if (mhs && last[g]) begin
                    m_locked = 1'b0;
                    m_rr     = (g + 1) % N;
                    m_beats  = 0;
                end else begin
                    m_locked = 1'b1;
                    m_gnt    = g;
                    if (mhs) begin
                        if (m_beats == MB - 1) m_ovr = 1'b1;
                        m_beats = (m_beats + 1 > MB) ? MB : m_beats + 1;
                    end
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        fready = 1'b0;
        en     = 4'b1111;
        for (int i = 0; i < 4; i++) load(i, 0, 1);
        apply();
        step();
        chk_on = 1'b1;
        step();
        rst_n = 1'b1;
        check("reset overrun", ovr, 0);
        check("reset valid", fvld, 0);
        hs_log.delete();

        // Round-robin single beats
        fready = 1'b1;
        load(0, 2, 1); load(1, 1, 1); load(2, 1, 1); load(3, 1, 1);
        apply();
        steps(7);
        check("rr count", hs_log.size(), 5);
        check("rr order", log_code(), 'h01230);
        hs_log.delete();

        // Packet lock: 1 sends three beats while 2 waits
        load(1, 3, 3); load(2, 1, 1);
        apply();
        steps(6);
        check("lock count", hs_log.size(), 4);
        check("lock order", log_code(), 'h1112);
        hs_log.delete();

        // Backpressure: 0 held through five stalled cycles, 3 shows up mid-stall
        fready = 1'b0;
        load(0, 1, 1);
        apply();
        steps(2);
        load(3, 1, 1);
        apply();
        steps(3);
        check("stall idx", fidx, 0);
        check("stall data", fdata, 8'h00);
        check("stall valid", fvld, 1);
        fready = 1'b1;
        steps(3);
        check("stall order", log_code(), 'h03);
        check("stall count", hs_log.size(), 2);
        hs_log.delete();

        // Enable mask, with en[1] dropped after the first beat of 1's packet
        en = 4'b1010;
        load(0, 1, 1); load(1, 3, 3); load(2, 1, 1); load(3, 1, 1);
        apply();
        step();
        en = 4'b1000;
        steps(5);
        check("mask order", log_code(), 'h1113);
        check("mask count", hs_log.size(), 4);
        check("mask idle", fvld, 0);
        left[0] = 0; left[2] = 0;
        en = 4'b1111;
        apply();
        hs_log.delete();

        // Overrun: six-beat packet with MaxBeats = 4
        load(2, 6, 6);
        apply();
        steps(3);
        check("ovr after 3", ovr, 0);
        step();
        check("ovr after 4", ovr, 1);
        steps(4);
        check("ovr sticky", ovr, 1);
        check("ovr order", log_code(), 'h222222);
        hs_log.delete();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("ovr cleared", ovr, 0);
        hs_log.delete();

        // Reset while 1 is locked two beats into a four-beat packet
        load(0, 1, 1);
        apply();
        step();
        load(1, 4, 4);
        apply();
        steps(2);
        load(0, 1, 1);
        apply();
        check("pre-reset idx", fidx, 1);
        fready = 1'b0;
        rst_n  = 1'b0;
        step();
        rst_n  = 1'b1;
        fready = 1'b1;
        hs_log.delete();
        check("post-reset idx", fidx, 0);
        steps(4);
        check("post-reset order", log_code(), 'h011);
        check("post-reset count", hs_log.size(), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
